// File: rtl/sample_window_reader_if.sv
// Stream interface carrying the windowed samples from the reader to the consumer.
// A beat transfers on a rising edge where m_valid and m_ready are both high.
interface sample_window_reader_if #(
  parameter int W = 16
);
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/sample_window_reader.sv
// Waits for the capture window to close, snapshots all stages at once, then
// streams them oldest-first with m_last on the newest sample.
module sample_window_reader #(
  parameter int N = 6,
  parameter int D = 3,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            count,
  input  logic [N*W-1:0]         samples,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state_o,
  sample_window_reader_if.master m
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // 17-bit close point so D+N-1 can never wrap against the 16-bit counter.
  localparam logic [16:0] CLOSE = 17'(D + N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N*W-1:0]  buf_q, buf_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        // Exact match only: a counter already past CLOSE must wrap around first.
        if ({1'b0, count} == CLOSE) begin
          buf_d   = samples;
          data_d  = samples[(N-1)*W +: W];
          valid_d = 1'b1;
          last_d  = (N == 1);
          idx_d   = IW'(N - 1);
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (valid_q && m.m_ready) begin
          if (idx_q == '0) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q - 1'b1;
            data_d = buf_q[int'(idx_d)*W +: W];
            last_d = (idx_d == '0);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m.m_data    = data_q;
  assign m.m_valid   = valid_q;
  assign m.m_last    = last_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sample_window_reader.sv
// Directed bench for sample_window_reader: a queue-based window model checked
// every cycle, plus literal expectations for beat values and timing.
module tb_sample_window_reader;

  localparam int N = 6;
  localparam int D = 3;
  localparam int W = 16;
  localparam int CLOSE = D + N - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [15:0]    count = '0;
  logic [N*W-1:0] samples = '0;
  logic           busy, done;
  logic [1:0]     dbg_state;

  logic           start1 = 1'b0;
  logic [W-1:0]   samples1 = 16'h8001;
  logic           busy1, done1;
  logic [1:0]     dbg_state1;

  sample_window_reader_if #(.W(W)) bus ();
  sample_window_reader_if #(.W(W)) bus1 ();

  sample_window_reader #(.N(N), .D(D), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .samples(samples),
    .busy(busy), .done(done), .dbg_state_o(dbg_state), .m(bus.master)
  );

  sample_window_reader #(.N(1), .D(1), .W(W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .count(count), .samples(samples1),
    .busy(busy1), .done(done1), .dbg_state_o(dbg_state1), .m(bus1.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit cnt_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Window model: a start arms it, the close count loads every stage
  // oldest-first into the queue, and each accepted beat pops one entry.
  logic [W-1:0] exp_q[$];
  bit           mdl_ok    = 1'b0;
  bit           mdl_armed = 1'b0;
  bit           exp_done  = 1'b0;
  logic [W-1:0] exp_data  = '0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_ok    = 1'b1;
      mdl_armed = 1'b0;
      exp_q.delete();
      exp_done  = 1'b0;
      exp_data  = '0;
    end else if (mdl_ok) begin
      exp_done = 1'b0;
      if (exp_q.size() > 0) begin
        if (bus.m_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_done = 1'b1;
        end
      end else if (mdl_armed) begin
        if (int'(count) == CLOSE) begin
          for (int k = N - 1; k >= 0; k--) exp_q.push_back(samples[k*W +: W]);
          mdl_armed = 1'b0;
        end
      end else if (start) begin
        mdl_armed = 1'b1;
      end
      if (exp_q.size() > 0) exp_data = exp_q[0];
    end
  end

  // Recorded traffic for the literal checks.
  logic [W-1:0] got_q[$];
  bit           got_last[$];
  int           close_cyc, first_vis, last_vis, done_cyc, stall30;
  bit           done_seen;

  always @(negedge clk) begin
    if (mdl_ok && !rst) begin
      chk("busy", 32'(busy), 32'(mdl_armed || exp_q.size() > 0));
      chk("m_valid", 32'(bus.m_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("m_last", 32'(bus.m_last), 32'(exp_q.size() == 1));
      chk("m_data", 32'(bus.m_data), 32'(exp_data));
      chk("done", 32'(done), 32'(exp_done));
      if (count == 16'(CLOSE)) close_cyc = cyc_n + 1;
      if (bus.m_valid && !bus.m_ready && bus.m_data == 16'd30) stall30++;
      if (bus.m_valid && bus.m_ready) begin
        if (got_q.size() == 0) first_vis = cyc_n;
        last_vis = cyc_n;
        got_q.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc_n;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (cnt_en) count = count + 16'd1;
  endtask

  task automatic clear_rec();
    got_q.delete();
    got_last.delete();
    done_seen = 1'b0;
    stall30   = 0;
    close_cyc = -100;
    first_vis = -1;
    done_cyc  = -1;
  endtask

  task automatic set_samples();
    for (int k = 0; k < N; k++) samples[k*W +: W] = 16'(60 - 10 * k);
  endtask

  task automatic begin_test();
    rst = 1'b1; start = 1'b0; cnt_en = 1'b0; count = '0; bus.m_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    rst = 1'b0;
    set_samples();
    clear_rec();
  endtask

  // mode 0: always ready; 1: stall three cycles on beat 30; 2: corrupt inputs after snapshot
  task automatic run_until_done(input int mode, input int budget);
    int stalls = 0;
    int n = 0;
    while (!done_seen && n < budget) begin
      cyc();
      n++;
      bus.m_ready = 1'b1;
      if (mode == 1 && bus.m_valid && bus.m_data == 16'd30 && stalls < 3) begin
        bus.m_ready = 1'b0;
        stalls++;
      end
      if (mode == 2 && bus.m_valid) samples = {N{16'hFFFF}};
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_beats"}, 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk({tag, "_val"}, 32'(got_q[i]), 32'(10 * (i + 1)));
        chk({tag, "_lastflag"}, 32'(got_last[i]), 32'(i == 5));
      end
    end
  endtask

  task automatic start_window();
    count = '0; cnt_en = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    bus.m_ready = 1'b1;
    bus1.m_ready = 1'b1;

    // Basic stream and timing
    begin_test();
    start_window();
    run_until_done(0, 60);
    check_stream("basic");
    chk("first_beat_lat", 32'(first_vis - close_cyc), 32'd0);
    chk("back_to_back", 32'(last_vis - first_vis), 32'd5);
    chk("done_lat", 32'(done_cyc - close_cyc), 32'd6);

    // Backpressure on beat 30
    begin_test();
    start_window();
    run_until_done(1, 60);
    check_stream("bp");
    chk("bp_stall_cycles", 32'(stall30), 32'd3);
    chk("bp_done_lat", 32'(done_cyc - close_cyc), 32'd9);

    // Snapshot isolation
    begin_test();
    start_window();
    run_until_done(2, 60);
    check_stream("iso");
    set_samples();

    // Stale counter: armed past CLOSE, must wait for the wrap
    begin_test();
    count = 16'd12; start = 1'b1;
    cyc();
    start = 1'b0; cnt_en = 1'b1;
    repeat (3) cyc();
    count = 16'd65533;
    repeat (5) cyc();
    @(negedge clk);
    chk("stale_no_beats", 32'(got_q.size()), 32'd0);
    chk("stale_busy", 32'(busy), 32'd1);
    run_until_done(0, 60);
    check_stream("stale");

    // Reset mid-stream after beat 30
    begin_test();
    start_window();
    for (int n = 0; n < 60 && got_q.size() < 3; n++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (12) cyc();
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    chk("midrst_beats", 32'(got_q.size()), 32'd3);
    clear_rec();
    start_window();
    run_until_done(0, 60);
    check_stream("fresh");

    // Start pulses while ARMED and STREAM are ignored
    begin_test();
    start_window();
    repeat (3) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 60 && got_q.size() < 2; n++) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(0, 60);
    repeat (20) cyc();
    check_stream("ign");
    chk("ign_idle_after", 32'(busy), 32'd0);

    // N=1, D=1 instance: single beat one cycle after count==1
    cnt_en = 1'b0; count = '0; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    @(negedge clk);
    chk("n1_armed_busy", 32'(busy1), 32'd1);
    chk("n1_armed_valid", 32'(bus1.m_valid), 32'd0);
    count = 16'd1;
    cyc();
    count = 16'd2;
    @(negedge clk);
    chk("n1_valid", 32'(bus1.m_valid), 32'd1);
    chk("n1_last", 32'(bus1.m_last), 32'd1);
    chk("n1_data", 32'(bus1.m_data), 32'h8001);
    cyc();
    @(negedge clk);
    chk("n1_after_valid", 32'(bus1.m_valid), 32'd0);
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_idle", 32'(busy1), 32'd0);
    chk("n1_data_hold", 32'(bus1.m_data), 32'h8001);
    cyc();
    @(negedge clk);
    chk("n1_done_pulse", 32'(done1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_window_reader.md
Name: sample_window_reader

Overview:
- Read side of the windowed sample-capture chain.
- The capture chain uses the shared 16-bit window counter: it loads N samples on the counter edges D-1 through D+N-2, shifting each new sample into stage 0.
- This block waits for that window to close, snapshots all N stages in one cycle, then streams the samples out oldest-first over a valid/ready interface, marking the final beat with last.
- It sits between the capture chain and the downstream processing/logging logic.

Parameters:
- N, 6, number of samples in the window (stages in the capture chain); range 1..64.
- D, 3, window delay in counter ticks; must match the capture chain's D.
- W, 16, sample width in bits (signed two's complement).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  arms the reader for one window; sampled only in IDLE.
- count  input  16  shared window counter, unsigned; the same counter that drives the capture chain.
- samples  input  N*W  capture-chain stage outputs; stage k occupies bits [k*W +: W]; stage N-1 is the oldest sample.
- busy  output  1  high in every state except IDLE.
- m_data  output  W  streamed sample.
- m_valid  output  1  m_data is valid.
- m_ready  input  1  downstream accepts the beat.
- m_last  output  1  marks the final beat of the window; meaningful only while m_valid=1.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset:
  - Synchronous: takes effect on a rising clk edge with rst=1, at any time, including mid-stream.
  - Result: state=IDLE; m_valid=0, m_last=0, done=0, busy=0, m_data=0; snapshot buffer and beat index cleared.
  - An in-flight window is discarded; nothing resumes after reset.
- Window-close point: CLOSE = D+N-1, computed at 17 bits so no overflow.
- States: IDLE, ARMED, STREAM.
- IDLE:
  - start=1 -> ARMED on the next edge.
  - All other inputs are ignored.
- ARMED:
  - Waits for count == CLOSE, using exact equality so a stale or already-past count cannot trigger.
  - Counter wrap-around (65535 -> 0) is ignored; the block keeps waiting until count next equals CLOSE.
  - On the edge where count == CLOSE:
    - buffer <= samples (all N stages captured in the same cycle);
    - m_data <= stage N-1; m_valid <= 1; m_last <= (N==1); beat index <= N-1;
    - state <= STREAM.
  - Latency: the first beat is visible one cycle after count==CLOSE is presented.
  - start is ignored in ARMED.
- STREAM:
  - A beat transfers on any edge with m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - The buffer is isolated: changes on samples after the snapshot do not affect the output.
  - Non-final beat accepted: next cycle presents stage index-1 and decrements the index. Back-to-back accepts give one beat per cycle.
  - m_last=1 exactly when the index is 0 (the stage 0 beat, newest sample).
  - Final beat accepted:
    - next cycle m_valid=0, m_last=0, done=1 for exactly one cycle, state=IDLE, busy=0.
    - m_data holds its last value.
  - start is ignored in STREAM; a start coincident with the done cycle is sampled in IDLE normally (done and start are independent).
- Beat order: stages N-1, N-2, ..., 0 (chronological, oldest first). Data is passed through unmodified, W bits, no arithmetic on samples.
- Beat count: exactly N beats per armed window; no beats without a preceding start.

Test Plan:
- Basic stream (N=6, D=3, W=16): start=1 in IDLE, count ramps 0..20, samples stage5..stage0 = 10,20,30,40,50,60, m_ready=1 -> with count=8 on edge t, beats 10,20,30,40,50,60 on t+1..t+6, m_last only with 60, done=1 at t+7, busy=0 at t+7.
- Backpressure: same setup, m_ready=0 for 3 cycles during the beat 30 -> m_data=30 with m_valid=1 held for 3 cycles, no beat dropped or duplicated, total 6 beats, done after beat 60.
- Snapshot isolation: change samples to 0xFFFF on the cycle after the snapshot -> streamed data is still 10..60.
- Stale counter: start while count=12 (past CLOSE=8), count keeps rising and wraps 65535->0 -> no beats until count hits 8 again; then the normal 6-beat stream.
- Reset mid-stream: rst=1 after beat 30 is accepted -> next cycle m_valid=0, busy=0, no done pulse. After a new start and window: a full fresh 6-beat stream.
- Ignored start and N=1: start pulses during ARMED/STREAM have no effect (exactly 6 beats). With N=1, D=1: the single beat has m_last=1 and appears one cycle after count==1.
